// File: rtl/mac_tree_pipe_pkg.sv
// rtl/mac_tree_pipe_pkg.sv - shared constants and helpers for the MAC adder-tree pipeline
package mac_tree_pipe_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_DW    = 16;
    localparam int DEF_FRAC  = 14;
    localparam int DEF_TAG_W = 16;
    localparam int SAT_VW    = 64;

    typedef struct packed {
        logic signed [SAT_VW-1:0] value;
        logic                     flag;
    } sat_t;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int mac_lat(input int n);
        return 2 + safe_clog2(n);
    endfunction

    // Operand count entering tree level l (level 0 is the product stage).
    function automatic int lvl_n(input int n, input int l);
        int r;
        r = n;
        for (int k = 0; k < l; k++) begin
            r = (r + 1) / 2;
        end
        return r;
    endfunction

    // Bit offset of level l inside the flattened tree bus; widths grow one bit per level.
    function automatic int lvl_off(input int n, input int pw, input int l);
        int off;
        off = 0;
        for (int k = 0; k < l; k++) begin
            off = off + lvl_n(n, k) * (pw + k);
        end
        return off;
    endfunction

    function automatic sat_t sat_to_w(input logic signed [SAT_VW-1:0] x, input int w);
        logic signed [SAT_VW-1:0] hi;
        logic signed [SAT_VW-1:0] lo;
        sat_t                     r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.value = x;
        r.flag  = 1'b0;
        if (x > hi) begin
            r.value = hi;
            r.flag  = 1'b1;
        end else if (x < lo) begin
            r.value = lo;
            r.flag  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_tree_pipe_if.sv
// rtl/mac_tree_pipe_if.sv - sample stream, coefficient write and result stream bundle
interface mac_tree_pipe_if
    import mac_tree_pipe_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int DW    = DEF_DW,
    parameter int TAG_W = DEF_TAG_W,
    parameter int CIW   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N_CH*DW-1:0]   in_data;
    logic [TAG_W-1:0]     in_tag;
    logic                 coef_wr_en;
    logic [CIW-1:0]       coef_wr_idx;
    logic [DW-1:0]        coef_wr_data;
    logic                 coef_commit;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_sat;

    modport master (
        output in_valid, in_data, in_tag, coef_wr_en, coef_wr_idx, coef_wr_data, coef_commit, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_tag, coef_wr_en, coef_wr_idx, coef_wr_data, coef_commit, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_sat
    );
endinterface

// File: rtl/mac_tree_pipe_add_tree_level.sv
// rtl/mac_tree_pipe_add_tree_level.sv - one registered pairwise-add level of the sum tree
module add_tree_level #(
    parameter int N_IN = 4,
    parameter int W    = 32,
    localparam int N_OUT = (N_IN + 1) / 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_IN*W-1:0]      in_bus,
    output logic [N_OUT*(W+1)-1:0] out_bus
);

    // An odd leftover operand is sign-extended and registered so all paths keep equal depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bus <= '0;
        end else if (en) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (2 * i + 1 < N_IN) begin
                    out_bus[i*(W+1) +: W+1] <= (W+1)'($signed(in_bus[2*i*W +: W]))
                                             + (W+1)'($signed(in_bus[(2*i+1)*W +: W]));
                end else begin
                    out_bus[i*(W+1) +: W+1] <= (W+1)'($signed(in_bus[2*i*W +: W]));
                end
            end
        end
    end

endmodule

// File: rtl/mac_tree_pipe.sv
// rtl/mac_tree_pipe.sv - N-channel coefficient MAC with registered adder tree and scaled output
module mac_tree_pipe
    import mac_tree_pipe_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int DW     = DEF_DW,
    parameter int FRAC   = DEF_FRAC,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int SAT_EN = 1
) (
    input logic            clk,
    input logic            rst,
    mac_tree_pipe_if.slave bus
);

    localparam int L2      = safe_clog2(N_CH);
    localparam int LAT     = mac_lat(N_CH);
    localparam int PW      = 2 * DW;
    localparam int SW      = PW + L2;
    localparam int CIW     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TREE_W  = lvl_off(N_CH, PW, L2 + 1);
    localparam int SUM_OFF = lvl_off(N_CH, PW, L2);

    logic                 stall;
    logic                 en;
    logic                 accept;
    logic signed [DW-1:0] shadow [N_CH];
    logic signed [DW-1:0] active [N_CH];
    logic [N_CH*PW-1:0]   prod_q;
    wire  [TREE_W-1:0]    tree_bus;
    logic [LAT-2:0]       vld_q;
    logic [TAG_W-1:0]     tag_q [LAT-1];

    logic signed [SW-1:0]     final_sum;
    logic signed [SW-1:0]     scaled;
    logic signed [SAT_VW-1:0] scaled_ext;
    sat_t                     sat_r;
    logic signed [DW-1:0]     res_data;
    logic                     res_sat;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign en           = ~stall;
    assign bus.in_ready = en;
    assign accept       = bus.in_valid & en;

    // Commit reads the shadow value from before this edge, so a same-cycle write stays shadow-only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.coef_wr_en && (bus.coef_wr_idx == CIW'(i))) begin
                    shadow[i] <= bus.coef_wr_data;
                end
                if (bus.coef_commit) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else if (en) begin
            for (int i = 0; i < N_CH; i++) begin
                prod_q[i*PW +: PW] <= PW'($signed(bus.in_data[i*DW +: DW])) * PW'(active[i]);
            end
        end
    end

    assign tree_bus[N_CH*PW-1:0] = prod_q;

    for (genvar l = 0; l < L2; l++) begin : g_lvl
        localparam int NI = lvl_n(N_CH, l);
        localparam int NO = lvl_n(N_CH, l + 1);
        localparam int WI = PW + l;
        localparam int OI = lvl_off(N_CH, PW, l);
        localparam int OO = lvl_off(N_CH, PW, l + 1);

        add_tree_level #(
            .N_IN (NI),
            .W    (WI)
        ) u_lvl (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .in_bus  (tree_bus[OI +: NI*WI]),
            .out_bus (tree_bus[OO +: NO*(WI+1)])
        );
    end

    assign final_sum  = $signed(tree_bus[SUM_OFF +: SW]);
    assign scaled     = final_sum >>> FRAC;
    assign scaled_ext = SAT_VW'(scaled);
    assign sat_r      = sat_to_w(scaled_ext, DW);

    always_comb begin
        res_data = DW'(scaled);
        res_sat  = 1'b0;
        if (SAT_EN != 0) begin
            res_data = DW'(sat_r.value);
            res_sat  = sat_r.flag;
        end
    end

    // Valid and tag advance with the datapath; bubbles move through rather than being squeezed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_tag   <= '0;
            bus.out_sat   <= 1'b0;
            for (int i = 0; i < LAT - 1; i++) begin
                tag_q[i] <= '0;
            end
        end else if (en) begin
            vld_q    <= {vld_q[LAT-3:0], accept};
            tag_q[0] <= bus.in_tag;
            for (int i = 1; i < LAT - 1; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            bus.out_valid <= vld_q[LAT-2];
            bus.out_tag   <= tag_q[LAT-2];
            bus.out_data  <= res_data;
            bus.out_sat   <= res_sat;
        end
    end

endmodule
